// File: rtl/drac_pkg.sv
// Shared types and constants for the execute-stage operand buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package drac_pkg;

    typedef logic [63:0] bus64_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // Fixed two-deep skid buffer between register read and the integer unit.
    localparam int EXE_BUF_DEPTH = 2;

    typedef struct packed {
        alu_op_t    alu_op;
        logic [4:0] rs1_idx;
        logic [4:0] rs2_idx;
        logic [4:0] rd_idx;
        logic       use_imm;
        bus64_t     op1;
        bus64_t     op2;
    } exe_entry_t;

endpackage

// File: rtl/exe_fwd_mux.sv
// Selects writeback data over register data when the writeback targets this index.
// Latency: combinational.
// Backpressure: none.
module exe_fwd_mux
    import drac_pkg::*;
(
    input  logic [4:0] idx_i,
    input  bus64_t     data_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    input  bus64_t     wb_data_i,
    output bus64_t     data_o
);

    // x0 is hardwired, so a writeback naming it never replaces the operand.
    assign data_o = (wb_we_i && (wb_rd_i == idx_i) && (idx_i != 5'd0)) ? wb_data_i : data_i;

endmodule

// File: rtl/exe_operand_stage.sv
// Two-entry operand buffer between register read and the integer unit, with writeback forwarding.
// Latency: one cycle from push to valid_o when empty.
// Backpressure: ready_o is registered and drops when both entries are held; ready_i stalls the head.
module exe_operand_stage
    import drac_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [4:0] rs1_idx_i,
    input  logic [4:0] rs2_idx_i,
    input  logic [4:0] rd_idx_i,
    input  bus64_t     data_rs1_i,
    input  bus64_t     data_rs2_i,
    input  bus64_t     imm_i,
    input  logic       use_imm_i,
    input  alu_op_t    alu_op_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    input  bus64_t     wb_data_i,
    output logic       valid_o,
    output bus64_t     data_rs1_o,
    output bus64_t     data_rs2_o,
    output alu_op_t    alu_op_o,
    output logic [4:0] rd_idx_o,
    input  logic       ready_i
);

    localparam int PTR_W = $clog2(EXE_BUF_DEPTH);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       occ_q;
    logic [1:0]       occ_next;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             ready_q;
    logic             push;
    logic             pop;

    exe_entry_t buf_q [EXE_BUF_DEPTH];
    exe_entry_t new_entry;
    exe_entry_t head;

    bus64_t push_op1;
    bus64_t push_op2_reg;
    bus64_t fwd_op1 [EXE_BUF_DEPTH];
    bus64_t fwd_op2 [EXE_BUF_DEPTH];

    assign push = valid_i && ready_q && !flush_i;
    assign pop  = valid_o && ready_i;

    // Operands arriving this cycle see a same-cycle writeback.
    exe_fwd_mux u_fwd_push_rs1 (
        .idx_i     (rs1_idx_i),
        .data_i    (data_rs1_i),
        .wb_we_i   (wb_we_i),
        .wb_rd_i   (wb_rd_i),
        .wb_data_i (wb_data_i),
        .data_o    (push_op1)
    );

    exe_fwd_mux u_fwd_push_rs2 (
        .idx_i     (rs2_idx_i),
        .data_i    (data_rs2_i),
        .wb_we_i   (wb_we_i),
        .wb_rd_i   (wb_rd_i),
        .wb_data_i (wb_data_i),
        .data_o    (push_op2_reg)
    );

    // Buffered operands keep snooping writebacks; an immediate is shielded by
    // presenting index 0, which the mux never forwards.
    for (genvar g = 0; g < EXE_BUF_DEPTH; g++) begin : g_entry_fwd
        exe_fwd_mux u_fwd_rs1 (
            .idx_i     (buf_q[g].rs1_idx),
            .data_i    (buf_q[g].op1),
            .wb_we_i   (wb_we_i),
            .wb_rd_i   (wb_rd_i),
            .wb_data_i (wb_data_i),
            .data_o    (fwd_op1[g])
        );

        exe_fwd_mux u_fwd_rs2 (
            .idx_i     (buf_q[g].use_imm ? 5'd0 : buf_q[g].rs2_idx),
            .data_i    (buf_q[g].op2),
            .wb_we_i   (wb_we_i),
            .wb_rd_i   (wb_rd_i),
            .wb_data_i (wb_data_i),
            .data_o    (fwd_op2[g])
        );
    end

    // Assemble the entry written on a push.
    always_comb begin
        new_entry         = '0;
        new_entry.alu_op  = alu_op_i;
        new_entry.rs1_idx = rs1_idx_i;
        new_entry.rs2_idx = rs2_idx_i;
        new_entry.rd_idx  = rd_idx_i;
        new_entry.use_imm = use_imm_i;
        new_entry.op1     = push_op1;
        new_entry.op2     = use_imm_i ? imm_i : push_op2_reg;
    end

    // Next occupancy: flush wins, otherwise push/pop adjust the count.
    always_comb begin
        occ_next = occ_q;
        if (flush_i) begin
            occ_next = EMPTY;
        end else if (push && !pop) begin
            occ_next = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ_q - 2'd1;
        end
    end

    // Occupancy, pointers and the registered ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q    <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            occ_q   <= occ_next;
            ready_q <= (occ_next != FULL);
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Entry storage: write on push, otherwise refresh operands from writeback.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < EXE_BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < EXE_BUF_DEPTH; i++) begin
                if (push && (wr_ptr_q == PTR_W'(i))) begin
                    buf_q[i] <= new_entry;
                end else begin
                    buf_q[i].op1 <= fwd_op1[i];
                    buf_q[i].op2 <= fwd_op2[i];
                end
            end
        end
    end

    assign head       = buf_q[rd_ptr_q];
    assign ready_o    = ready_q;
    assign valid_o    = (occ_q != EMPTY);
    assign data_rs1_o = valid_o ? head.op1    : '0;
    assign data_rs2_o = valid_o ? head.op2    : '0;
    assign alu_op_o   = valid_o ? head.alu_op : alu_op_t'(4'd0);
    assign rd_idx_o   = valid_o ? head.rd_idx : 5'd0;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed bench for exe_operand_stage: vector table plus buffering, flush and reset sequences.
module tb_exe_operand_stage;
    import drac_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       valid_i;
    logic       ready_o;
    logic [4:0] rs1_idx_i, rs2_idx_i, rd_idx_i;
    bus64_t     data_rs1_i, data_rs2_i, imm_i;
    logic       use_imm_i;
    alu_op_t    alu_op_i;
    logic       wb_we_i;
    logic [4:0] wb_rd_i;
    bus64_t     wb_data_i;
    logic       valid_o;
    bus64_t     data_rs1_o, data_rs2_o;
    alu_op_t    alu_op_o;
    logic [4:0] rd_idx_o;
    logic       ready_i;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    exe_operand_stage dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .rs1_idx_i  (rs1_idx_i),
        .rs2_idx_i  (rs2_idx_i),
        .rd_idx_i   (rd_idx_i),
        .data_rs1_i (data_rs1_i),
        .data_rs2_i (data_rs2_i),
        .imm_i      (imm_i),
        .use_imm_i  (use_imm_i),
        .alu_op_i   (alu_op_i),
        .wb_we_i    (wb_we_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .valid_o    (valid_o),
        .data_rs1_o (data_rs1_o),
        .data_rs2_o (data_rs2_o),
        .alu_op_o   (alu_op_o),
        .rd_idx_o   (rd_idx_o),
        .ready_i    (ready_i)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        bus64_t     d1, d2, imm;
        logic       use_imm;
        alu_op_t    op;
        logic       we;
        logic [4:0] wrd;
        bus64_t     wdat;
        bus64_t     exp1, exp2;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input bus64_t d1, input bus64_t d2, input bus64_t imm,
                         input logic use_imm, input alu_op_t op);
        valid_i    = 1'b1;
        rs1_idx_i  = rs1;
        rs2_idx_i  = rs2;
        rd_idx_i   = rd;
        data_rs1_i = d1;
        data_rs2_i = d2;
        imm_i      = imm;
        use_imm_i  = use_imm;
        alu_op_i   = op;
    endtask

    task automatic idle_in();
        valid_i = 1'b0;
        wb_we_i = 1'b0;
        wb_rd_i = 5'd0;
        wb_data_i = '0;
    endtask

    task automatic fill_full();
        ready_i = 1'b0;
        @(negedge clk_i);
        drive(5'd1, 5'd2, 5'd10, 64'h11, 64'h12, 64'h0, 1'b0, ALU_ADD);
        @(negedge clk_i);
        drive(5'd3, 5'd4, 5'd11, 64'h21, 64'h22, 64'h0, 1'b0, ALU_SUB);
        @(negedge clk_i);
        idle_in();
    endtask

    initial begin
        //        rs1   rs2   rd     d1          d2        imm     use   op        we    wrd   wdat        exp1        exp2
        vecs[0] = '{5'd1, 5'd2, 5'd5, 64'd5,  64'd7,  64'h0,  1'b0, ALU_ADD, 1'b0, 5'd0, 64'h0,      64'd5,      64'd7};
        vecs[1] = '{5'd3, 5'd2, 5'd6, 64'd1,  64'd9,  64'h0,  1'b0, ALU_SUB, 1'b1, 5'd3, 64'hAA,     64'hAA,     64'd9};
        vecs[2] = '{5'd0, 5'd0, 5'd7, 64'h55, 64'h66, 64'h0,  1'b0, ALU_AND, 1'b1, 5'd0, 64'hAA,     64'h55,     64'h66};
        vecs[3] = '{5'd5, 5'd4, 5'd8, 64'h77, 64'd3,  64'h10, 1'b1, ALU_OR,  1'b1, 5'd4, 64'h1234,   64'h77,     64'h10};
        vecs[4] = '{5'd7, 5'd7, 5'd9, 64'd2,  64'd1,  64'h0,  1'b0, ALU_XOR, 1'b1, 5'd7, 64'hBEEF,   64'hBEEF,   64'hBEEF};
        vecs[5] = '{5'd8, 5'd9, 5'd1, 64'h31, 64'h32, 64'h0,  1'b0, ALU_SLT, 1'b0, 5'd8, 64'hDEAD,   64'h31,     64'h32};
        vecs[6] = '{5'd9, 5'd8, 5'd31,64'h41, 64'h42, 64'h0,  1'b0, ALU_SRA, 1'b1, 5'd8, 64'hCAFE,   64'h41,     64'hCAFE};

        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        idle_in();
        drive(5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, ALU_ADD);
        valid_i = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_op1", data_rs1_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", ready_o, 1);
        chk("post_rst_valid", valid_o, 0);

        // Table-driven single-instruction vectors
        for (int i = 0; i < 7; i++) begin
            ready_i = 1'b1;
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
                  vecs[i].imm, vecs[i].use_imm, vecs[i].op);
            wb_we_i = vecs[i].we; wb_rd_i = vecs[i].wrd; wb_data_i = vecs[i].wdat;
            @(negedge clk_i);
            idle_in();
            chk($sformatf("v%0d_valid", i), valid_o, 1);
            chk($sformatf("v%0d_op1", i), data_rs1_o, vecs[i].exp1);
            chk($sformatf("v%0d_op2", i), data_rs2_o, vecs[i].exp2);
            chk($sformatf("v%0d_alu", i), alu_op_o, vecs[i].op);
            chk($sformatf("v%0d_rd", i), rd_idx_o, vecs[i].rd);
            @(negedge clk_i);
            chk($sformatf("v%0d_drained", i), valid_o, 0);
            chk($sformatf("v%0d_zero_op1", i), data_rs1_o, 0);
        end

        // Back-to-back pushes against a stalled consumer
        ready_i = 1'b0;
        drive(5'd1, 5'd2, 5'd1, 64'hA0, 64'h0, 64'h0, 1'b0, ALU_ADD);
        @(negedge clk_i);
        chk("bb_ready_one", ready_o, 1);
        chk("bb_head_a", data_rs1_o, 64'hA0);
        drive(5'd1, 5'd2, 5'd2, 64'hB0, 64'h0, 64'h0, 1'b0, ALU_SUB);
        @(negedge clk_i);
        chk("bb_ready_full", ready_o, 0);
        drive(5'd1, 5'd2, 5'd3, 64'hC0, 64'h0, 64'h0, 1'b0, ALU_AND);
        @(negedge clk_i);
        chk("bb_held_ready", ready_o, 0);
        chk("bb_held_head", data_rs1_o, 64'hA0);
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("bb_ready_after_pop", ready_o, 1);
        chk("bb_head_b", data_rs1_o, 64'hB0);
        @(negedge clk_i);
        idle_in();
        chk("bb_head_c", data_rs1_o, 64'hC0);
        chk("bb_alu_c", alu_op_o, ALU_AND);
        @(negedge clk_i);
        chk("bb_empty", valid_o, 0);

        // Writeback updates a buffered register operand but not an immediate
        ready_i = 1'b0;
        drive(5'd6, 5'd4, 5'd12, 64'h2, 64'h1, 64'h0, 1'b0, ALU_ADD);
        @(negedge clk_i);
        drive(5'd6, 5'd4, 5'd13, 64'h2, 64'h1, 64'h10, 1'b1, ALU_ADD);
        @(negedge clk_i);
        idle_in();
        wb_we_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 64'h1234;
        @(negedge clk_i);
        idle_in();
        ready_i = 1'b1;
        chk("buf_fwd_op2", data_rs2_o, 64'h1234);
        chk("buf_fwd_op1_untouched", data_rs1_o, 64'h2);
        @(negedge clk_i);
        chk("buf_imm_kept", data_rs2_o, 64'h10);
        chk("buf_imm_rd", rd_idx_o, 5'd13);
        @(negedge clk_i);
        chk("buf_empty", valid_o, 0);

        // Flush of a full buffer with a same-cycle valid input
        fill_full();
        chk("fl_full_ready", ready_o, 0);
        flush_i = 1'b1;
        drive(5'd5, 5'd5, 5'd20, 64'hF1, 64'hF2, 64'h0, 1'b0, ALU_XOR);
        @(negedge clk_i);
        flush_i = 1'b0;
        idle_in();
        chk("fl_valid", valid_o, 0);
        chk("fl_ready", ready_o, 1);
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("fl_never_issued", valid_o, 0);

        // Flush beats a push that would otherwise be accepted
        ready_i = 1'b0;
        drive(5'd1, 5'd1, 5'd21, 64'hE1, 64'h0, 64'h0, 1'b0, ALU_ADD);
        @(negedge clk_i);
        chk("fl1_valid_before", valid_o, 1);
        flush_i = 1'b1;
        drive(5'd1, 5'd1, 5'd22, 64'hE2, 64'h0, 64'h0, 1'b0, ALU_ADD);
        @(negedge clk_i);
        flush_i = 1'b0;
        idle_in();
        chk("fl1_valid", valid_o, 0);
        chk("fl1_ready", ready_o, 1);
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("fl1_no_push", valid_o, 0);

        // Asynchronous reset with a full buffer
        fill_full();
        chk("ar_full_valid", valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("ar_valid", valid_o, 0);
        chk("ar_ready", ready_o, 0);
        chk("ar_op1", data_rs1_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("ar_ready_low_before_edge", ready_o, 0);
        @(negedge clk_i);
        chk("ar_ready_after", ready_o, 1);
        chk("ar_valid_after", valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/exe_operand_stage.md
EXE_OPERAND_STAGE -- requirements
Module: exe_operand_stage

Interface
REQ-001 No module parameters SHALL exist; buffer depth SHALL be drac_pkg constant EXE_BUF_DEPTH, default 2, fixed.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk_i  in  1  clock; all state on rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 flush_i  in  1  discard all buffered and incoming instructions.
REQ-006 valid_i  in  1  upstream (register read) instruction valid.
REQ-007 ready_o  out  1  stage can accept; registered.
REQ-008 rs1_idx_i, rs2_idx_i, rd_idx_i  in  5 each  source/dest register indices.
REQ-009 data_rs1_i, data_rs2_i  in  bus64_t  register file read data.
REQ-010 imm_i  in  bus64_t  immediate; use_imm_i  in  1  select immediate as operand 2.
REQ-011 alu_op_i  in  alu_op_t  operation for integer unit.
REQ-012 wb_we_i  in  1, wb_rd_i  in  5, wb_data_i  in  bus64_t  writeback forwarding port.
REQ-013 valid_o  out  1; data_rs1_o, data_rs2_o  out  bus64_t; alu_op_o  out  alu_op_t; rd_idx_o  out  5  head entry to integer unit.
REQ-014 ready_i  in  1  integer unit accepts head (de-asserted while its stall is high).

Function
REQ-015 Push SHALL occur when valid_i && ready_o && !flush_i; pop when valid_o && ready_i.
REQ-016 Occupancy states EMPTY(0), ONE(1), FULL(2) SHALL be held; push-only increments, pop-only decrements, push+pop holds.
REQ-017 ready_o SHALL be 1 in EMPTY and ONE, 0 in FULL, registered from next-state occupancy.
REQ-018 Latency: pushed instruction SHALL appear on outputs with valid_o=1 the cycle after push when buffer was empty.
REQ-019 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo 2.
REQ-020 Operand 2 captured SHALL be imm_i when use_imm_i=1, else rs2 data; use_imm SHALL be stored per entry.
REQ-021 At push, a register operand SHALL take wb_data_i when wb_we_i=1, wb_rd_i equals its index and index is nonzero; otherwise regfile data.
REQ-022 Each cycle, every valid buffered entry SHALL overwrite a register operand (not an immediate) matching a nonzero wb_rd_i with wb_we_i=1.
REQ-023 Index 0 SHALL never be forwarded; operand SHALL equal data supplied at push.
REQ-024 Output fields when valid_o=0 SHALL be zero.
REQ-025 flush_i SHALL empty the buffer next cycle, has priority over same-cycle push, and a same-cycle pop is still counted consumed downstream.
REQ-026 After flush, valid_o=0 and ready_o=1 the following cycle.

Reset
REQ-027 On rst_i assertion, immediately: occupancy EMPTY, pointers 0, valid_o=0, all data outputs 0, ready_o=0 while rst_i high.
REQ-028 ready_o SHALL rise the first clock edge after rst_i deasserts; reset mid-transfer SHALL drop all entries.

Structure
REQ-029 drac_pkg SHALL hold EXE_BUF_DEPTH and exe_entry_t {alu_op, rs1_idx, rs2_idx, rd_idx, use_imm, op1, op2}; bus64_t and alu_op_t reused.
REQ-030 One combinational sub-module exe_fwd_mux (index, data, wb port -> forwarded data) SHALL be instantiated for push operands and each stored operand.

Verification
REQ-031 Push ADD rs1=x1(5), rs2=x2(7), ready_i=1 -> next cycle valid_o=1, op1=5, op2=7, alu_op_o=ALU_ADD.
REQ-032 ready_i=0, push three back-to-back -> first two accepted, ready_o=0 after second, third held upstream; ready_i=1 -> outputs in order.
REQ-033 Push rs1=x3 regfile 1 with wb_we_i=1, wb_rd_i=3, wb_data_i=0xAA -> op1_o=0xAA; same with wb_rd_i=0, rs1=x0 -> op1_o=regfile value.
REQ-034 Entry buffered (ready_i=0) with rs2=x4 and use_imm_i=0; later wb x4=0x1234 -> op2_o=0x1234 when popped; with use_imm_i=1, imm=0x10 -> op2_o=0x10 unchanged.
REQ-035 FULL buffer, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, flushed instruction never issued.
REQ-036 rst_i asserted asynchronously with FULL buffer -> valid_o=0 immediately, ready_o=1 one edge after release.
